// File: rtl/l2_req_scheduler_pkg.sv
// Shared types and defaults for the L2 request scheduler.
package l2_req_scheduler_pkg;

  typedef enum logic {
    IDLE,
    FLUSH_WALK
  } sched_state_t;

  localparam int unsigned L2_SCHED_STARVE_LIMIT = 8;

endpackage

// File: rtl/l2_req_scheduler_flush_walker.sv
// Set/way counter for the flush walk: clr restarts at (0,0), step advances way-major.
module l2_flush_walker
  import l2_req_scheduler_pkg::*;
#(
  parameter int unsigned N_SETS = 256,
  parameter int unsigned N_WAYS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      step,
  output logic [$clog2(N_SETS)-1:0] set,
  output logic [$clog2(N_WAYS)-1:0] way,
  output logic                      last
);

  localparam int unsigned SET_W = $clog2(N_SETS);
  localparam int unsigned WAY_W = $clog2(N_WAYS);

  // Both sizes are powers of two, so the final step wraps both counters to 0.
  assign last = (set == '1) && (way == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set <= '0;
      way <= '0;
    end else if (clr) begin
      set <= '0;
      way <= '0;
    end else if (step) begin
      way <= way + WAY_W'(1);
      if (way == '1) set <= set + SET_W'(1);
    end
  end

endmodule

// File: rtl/l2_req_scheduler.sv
// Per-cycle source arbitration for the L2 lookup pipeline, including flush walk.
// Optional CPU starvation promotion is enabled with `define L2_SCHED_STARVE_EN.
module l2_req_scheduler
  import l2_req_scheduler_pkg::*;
#(
  parameter int unsigned N_SETS       = 256,
  parameter int unsigned N_WAYS       = 8,
  parameter int unsigned STARVE_LIMIT = L2_SCHED_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rsp_valid,
  input  logic                      fwd_valid,
  input  logic                      cpu_valid,
  input  logic                      flush_valid,
  input  logic                      flush_is_all,
  input  logic                      pipe_ready,
  input  logic                      set_conflict,
  input  logic                      evict_stall,
  input  logic                      ongoing_atomic,
  input  logic                      fwd_stall,
  input  logic                      reqs_empty,
  output logic                      do_rsp,
  output logic                      do_fwd,
  output logic                      do_cpu_req,
  output logic                      do_flush,
  output logic                      do_ongoing_flush,
  output logic                      rsp_ready,
  output logic                      fwd_ready,
  output logic                      cpu_ready,
  output logic                      flush_ready,
  output logic [$clog2(N_SETS)-1:0] flush_set,
  output logic [$clog2(N_WAYS)-1:0] flush_way,
  output logic                      flush_all,
  output logic                      flush_done
);

  if ((N_SETS < 2) || ((N_SETS & (N_SETS - 1)) != 0) ||
      (N_WAYS < 2) || ((N_WAYS & (N_WAYS - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_param_check
    $error("l2_req_scheduler: N_SETS/N_WAYS must be powers of two >= 2, STARVE_LIMIT >= 1");
  end

  sched_state_t state, state_nxt;
  logic fwd_elig, cpu_elig, flush_elig, walk_elig;
  logic promote;
  logic walk_last;

  assign fwd_elig   = fwd_valid & ~fwd_stall;
  assign cpu_elig   = cpu_valid & ~set_conflict & ~evict_stall & ~ongoing_atomic & (state == IDLE);
  assign flush_elig = flush_valid & reqs_empty & (state == IDLE);
  assign walk_elig  = (state == FLUSH_WALK);

`ifdef L2_SCHED_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign promote = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Saturated count holds while a higher source (rsp) keeps winning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       starve_cnt <= '0;
    else if (!cpu_elig || do_cpu_req) starve_cnt <= '0;
    else if (pipe_ready && !promote) starve_cnt <= starve_cnt + CNT_W'(1);
  end
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    do_rsp           = 1'b0;
    do_fwd           = 1'b0;
    do_cpu_req       = 1'b0;
    do_flush         = 1'b0;
    do_ongoing_flush = 1'b0;
    state_nxt        = state;
    if (rst && pipe_ready) begin
      if (rsp_valid)                do_rsp           = 1'b1;
      else if (promote && cpu_elig) do_cpu_req       = 1'b1;
      else if (fwd_elig)            do_fwd           = 1'b1;
      else if (walk_elig)           do_ongoing_flush = 1'b1;
      else if (flush_elig)          do_flush         = 1'b1;
      else if (cpu_elig)            do_cpu_req       = 1'b1;
    end
    case (state)
      IDLE:       if (do_flush) state_nxt = FLUSH_WALK;
      FLUSH_WALK: if (do_ongoing_flush && walk_last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign rsp_ready   = do_rsp;
  assign fwd_ready   = do_fwd;
  assign cpu_ready   = do_cpu_req;
  assign flush_ready = do_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flush_all  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= do_ongoing_flush & walk_last;
      if (do_flush) flush_all <= flush_is_all;
    end
  end

  l2_flush_walker #(
    .N_SETS(N_SETS),
    .N_WAYS(N_WAYS)
  ) u_walker (
    .clk  (clk),
    .rst  (rst),
    .clr  (do_flush),
    .step (do_ongoing_flush),
    .set  (flush_set),
    .way  (flush_way),
    .last (walk_last)
  );

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Scoreboard bench for l2_req_scheduler with a small 4-set x 2-way flush walk.
module tb_l2_req_scheduler;

  localparam int unsigned N_SETS = 4;
  localparam int unsigned N_WAYS = 2;

  localparam logic [10:0] RSP  = 11'h400;
  localparam logic [10:0] FWD  = 11'h200;
  localparam logic [10:0] CPU  = 11'h100;
  localparam logic [10:0] FLV  = 11'h080;
  localparam logic [10:0] FALL = 11'h040;
  localparam logic [10:0] PR   = 11'h020;
  localparam logic [10:0] SC   = 11'h010;
  localparam logic [10:0] ES   = 11'h008;
  localparam logic [10:0] OA   = 11'h004;
  localparam logic [10:0] FS   = 11'h002;
  localparam logic [10:0] RE   = 11'h001;

  localparam logic [4:0] G_NONE = 5'b00000;
  localparam logic [4:0] G_RSP  = 5'b10000;
  localparam logic [4:0] G_FWD  = 5'b01000;
  localparam logic [4:0] G_CPU  = 5'b00100;
  localparam logic [4:0] G_FL   = 5'b00010;
  localparam logic [4:0] G_OF   = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rsp_valid = 0, fwd_valid = 0, cpu_valid = 0, flush_valid = 0, flush_is_all = 0;
  logic pipe_ready = 0, set_conflict = 0, evict_stall = 0, ongoing_atomic = 0;
  logic fwd_stall = 0, reqs_empty = 0;
  logic do_rsp, do_fwd, do_cpu_req, do_flush, do_ongoing_flush;
  logic rsp_ready, fwd_ready, cpu_ready, flush_ready;
  logic [1:0] flush_set;
  logic       flush_way;
  logic       flush_all, flush_done;

  typedef struct {
    logic [4:0] g;
    logic       dn;
    logic       fa;
    int         s;
    int         w;
    string      nm;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_req_scheduler #(
    .N_SETS(N_SETS),
    .N_WAYS(N_WAYS),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .fwd_valid(fwd_valid), .cpu_valid(cpu_valid),
    .flush_valid(flush_valid), .flush_is_all(flush_is_all), .pipe_ready(pipe_ready),
    .set_conflict(set_conflict), .evict_stall(evict_stall), .ongoing_atomic(ongoing_atomic),
    .fwd_stall(fwd_stall), .reqs_empty(reqs_empty),
    .do_rsp(do_rsp), .do_fwd(do_fwd), .do_cpu_req(do_cpu_req), .do_flush(do_flush),
    .do_ongoing_flush(do_ongoing_flush),
    .rsp_ready(rsp_ready), .fwd_ready(fwd_ready), .cpu_ready(cpu_ready), .flush_ready(flush_ready),
    .flush_set(flush_set), .flush_way(flush_way), .flush_all(flush_all), .flush_done(flush_done)
  );

  task automatic cyc(input logic [10:0] in, input logic [4:0] g, input logic dn,
                     input logic fa, input int s, input int w, input string nm);
    exp_t e;
    @(posedge clk); #1;
    {rsp_valid, fwd_valid, cpu_valid, flush_valid, flush_is_all, pipe_ready,
     set_conflict, evict_stall, ongoing_atomic, fwd_stall, reqs_empty} = in;
    e.g = g; e.dn = dn; e.fa = fa; e.s = s; e.w = w; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: compares the DUT outputs of the cycle each expectation was issued for.
  initial begin
    exp_t e;
    logic [4:0] gv;
    logic [3:0] rv;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        gv = {do_rsp, do_fwd, do_cpu_req, do_flush, do_ongoing_flush};
        rv = {rsp_ready, fwd_ready, cpu_ready, flush_ready};
        n_chk++;
        if (gv !== e.g) begin
          n_fail++;
          $display("FAIL %s grant: got %b expected %b", e.nm, gv, e.g);
        end
        n_chk++;
        if (rv !== e.g[4:1]) begin
          n_fail++;
          $display("FAIL %s ready: got %b expected %b", e.nm, rv, e.g[4:1]);
        end
        n_chk++;
        if (flush_done !== e.dn) begin
          n_fail++;
          $display("FAIL %s flush_done: got %b expected %b", e.nm, flush_done, e.dn);
        end
        n_chk++;
        if (flush_all !== e.fa) begin
          n_fail++;
          $display("FAIL %s flush_all: got %b expected %b", e.nm, flush_all, e.fa);
        end
        n_chk++;
        if (flush_set !== e.s[1:0] || flush_way !== e.w[0]) begin
          n_fail++;
          $display("FAIL %s set/way: got (%0d,%0d) expected (%0d,%0d)",
                   e.nm, flush_set, flush_way, e.s, e.w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] g9;
`ifdef L2_SCHED_STARVE_EN
    g9 = G_CPU;
`else
    g9 = G_FWD;
`endif
    // Reset state: everything offered, nothing granted.
    cyc(RSP | FWD | CPU | FLV | PR | RE, G_NONE, 0, 0, 0, 0, "reset");
    @(negedge clk); #1 rst = 1'b1;

    cyc(RSP | FWD | CPU | PR, G_RSP, 0, 0, 0, 0, "prio_rsp");
    cyc(FWD | CPU | PR,       G_FWD, 0, 0, 0, 0, "prio_fwd");
    cyc(CPU | PR,             G_CPU, 0, 0, 0, 0, "prio_cpu");
    cyc(FWD | CPU | PR | FS,  G_CPU, 0, 0, 0, 0, "fwd_stall");
    cyc(FWD | CPU | PR | SC,  G_FWD, 0, 0, 0, 0, "set_conflict");
    cyc(FWD | CPU | PR | ES,  G_FWD, 0, 0, 0, 0, "evict_stall");
    cyc(CPU | PR | OA,        G_NONE, 0, 0, 0, 0, "atomic");
    cyc(RSP | FWD | CPU,      G_NONE, 0, 0, 0, 0, "no_pipe_ready");

    // Starvation: 8 lost cycles, then cpu promoted (or not, without the feature).
    for (int i = 0; i < 8; i++) cyc(FWD | CPU | PR, G_FWD, 0, 0, 0, 0, "starve_fwd");
    cyc(FWD | CPU | PR, g9, 0, 0, 0, 0, "starve_9th");
    cyc(CPU | PR, G_CPU, 0, 0, 0, 0, "cpu_clear");
    for (int i = 0; i < 8; i++) cyc(FWD | CPU | PR, G_FWD, 0, 0, 0, 0, "starve_fwd2");
    cyc(RSP | FWD | CPU | PR, G_RSP, 0, 0, 0, 0, "rsp_over_promoted");
    cyc(FWD | CPU | PR, g9, 0, 0, 0, 0, "still_promoted");
    cyc(CPU | PR, G_CPU, 0, 0, 0, 0, "cpu_clear2");

    // Full walk with interruptions; the step at (2,1) loses to rsp once.
    cyc(FLV | FALL | RE | PR | CPU, G_FL, 0, 0, 0, 0, "flush_start");
    for (int k = 0; k < 8; k++) begin
      if (k == 1) cyc(11'h000, G_NONE, 0, 1, 0, 1, "walk_hold");
      if (k == 5) cyc(RSP | PR, G_RSP, 0, 1, 2, 1, "walk_rsp");
      if (k == 3) cyc(FLV | RE | PR | CPU, G_OF, 0, 1, k / 2, k % 2, "walk_ignore");
      else        cyc(PR, G_OF, 0, 1, k / 2, k % 2, "walk_step");
    end
    cyc(PR, G_NONE, 1, 1, 0, 0, "flush_done");
    cyc(PR, G_NONE, 0, 1, 0, 0, "done_pulse_end");

    // Flush gated by reqs_empty, then reset mid-walk.
    cyc(FLV | PR, G_NONE, 0, 1, 0, 0, "flush_wait");
    cyc(FLV | PR, G_NONE, 0, 1, 0, 0, "flush_wait2");
    cyc(FLV | PR | RE, G_FL, 0, 1, 0, 0, "flush_start2");
    for (int k = 0; k < 3; k++) cyc(PR, G_OF, 0, 0, k / 2, k % 2, "walk2_step");
    @(negedge clk); #1 rst = 1'b0;
    cyc(PR | CPU | RSP, G_NONE, 0, 0, 0, 0, "reset_mid_walk");
    @(negedge clk); #1 rst = 1'b1;
    cyc(PR | CPU, G_CPU, 0, 0, 0, 0, "after_reset_idle");
    cyc(PR, G_NONE, 0, 0, 0, 0, "no_done_after_reset");

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_req_scheduler.md
# l2_req_scheduler

Per-cycle request scheduler for the L2 cache pipeline. It decides which input source enters the lookup pipeline each cycle: response, forward, CPU request, flush start or next flush step. It applies stall rules and bounded CPU starvation, and walks every set/way during a flush. It sits between the L2 input interfaces and the input decoder/FSM. It produces the one-hot `do_*` selects and the input ready signals.

## Interface
Parameters:
- `N_SETS`, 256: L2 sets; power of two.
- `N_WAYS`, 8: L2 ways; power of two.
- `STARVE_LIMIT`, 8: consecutive lost eligible cycles before the CPU request is promoted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `rsp_valid`, `fwd_valid`, `cpu_valid`, `flush_valid` in 1 each: pending input requests.
- `flush_is_all` in 1: flush also invalidates clean lines; registered at flush start.
- `pipe_ready` in 1: decode stage can accept a request this cycle.
- `set_conflict`, `evict_stall`, `ongoing_atomic` in 1 each: block CPU requests.
- `fwd_stall` in 1: blocks forwards.
- `reqs_empty` in 1: no outstanding REQS entries.
- `do_rsp`, `do_fwd`, `do_cpu_req`, `do_flush`, `do_ongoing_flush` out 1 each: one-hot grant.
- `rsp_ready`, `fwd_ready`, `cpu_ready`, `flush_ready` out 1 each: equal to the matching grant.
- `flush_set` out log2(N_SETS): set for the current flush step.
- `flush_way` out log2(N_WAYS): way for the current flush step.
- `flush_all` out 1: registered `flush_is_all`.
- `flush_done` out 1: one-cycle pulse when the walk completes.

## Operation
- States:
  - IDLE.
  - FLUSH_WALK.
- No grant is issued when `pipe_ready`=0. At most one grant per cycle.
- Eligibility:
  - rsp: `rsp_valid`.
  - fwd: `fwd_valid & ~fwd_stall`.
  - cpu: `cpu_valid & ~set_conflict & ~evict_stall & ~ongoing_atomic` and state IDLE.
  - flush start: `flush_valid & reqs_empty` and state IDLE.
  - walk step: state FLUSH_WALK.
- Priority, highest first:
  1. rsp
  2. fwd
  3. walk step
  4. flush start
  5. cpu
- Promoted CPU priority: when promoted, cpu ranks above fwd but stays below rsp.
- Starvation counter `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, each cycle cpu is eligible and `pipe_ready`=1 but cpu is not granted.
  - Clears on a cpu grant and whenever cpu is ineligible.
  - Promotion is active while `starve_cnt`==STARVE_LIMIT.
- Flush start (`do_flush`):
  - Latches `flush_is_all`.
  - Clears the set/way counters.
  - Enters FLUSH_WALK.
  - Issues no walk step in the same cycle.
- Walk step (`do_ongoing_flush`):
  - Presents the current `flush_set`/`flush_way`, then increments the way.
  - Way wraps N_WAYS-1 -> 0 and increments the set.
  - The step with set N_SETS-1, way N_WAYS-1 is the last: the next cycle pulses `flush_done` and returns to IDLE with counters at 0.
- A walk step lost to rsp/fwd keeps its set/way; there are no skips and no repeats.
- `flush_valid` while in FLUSH_WALK is ignored: `flush_ready`=0.

## Timing
- Grants and readies are combinational from the inputs and registered state. Zero-cycle decision latency.
- State, counters, `flush_all` and `flush_done` are registered.
- Reset values:
  - state IDLE.
  - `starve_cnt`, `flush_set`, `flush_way` 0.
  - `flush_all` 0.
  - `flush_done` 0.
  - All grants 0 while `rst`=0.
- Reset asserted mid-walk aborts the walk. No `flush_done` is issued.
- Full walk with no interference: `do_flush` at cycle t, steps at t+1..t+N_SETS*N_WAYS, `flush_done` at t+N_SETS*N_WAYS+1.
- Simultaneous rsp and promoted cpu: rsp wins and the counter stays saturated.

## Configuration
- `L2_SCHED_STARVE_EN` defined: starvation counter and promotion are present as above.
- Undefined: strict fixed priority. `starve_cnt` is not instantiated and cpu never outranks fwd.

## Structure
- `sched_state_t` (IDLE/FLUSH_WALK) goes in `cache_types.svh`.
- `L2_SCHED_STARVE_LIMIT` default goes in `cache_consts.svh`.
- Sub-module `l2_flush_walker`: set/way counter with `clr`/`step` inputs and `last` output.
- Arbitration and the FSM stay in the top module.

## Test plan
- Same-cycle priority: `rsp_valid`=`fwd_valid`=`cpu_valid`=1, `pipe_ready`=1 -> `do_rsp` only; drop rsp -> `do_fwd`; drop fwd -> `do_cpu_req`.
- `fwd_stall`=1 with fwd and cpu valid -> `do_cpu_req`. `set_conflict`=1 -> no cpu grant and `starve_cnt` stays 0.
- Continuous `fwd_valid`, cpu eligible, STARVE_LIMIT=8 -> 8 `do_fwd` grants, then `do_cpu_req` on the 9th cycle. With the macro undefined, cpu is never granted.
- Flush walk, N_SETS=4, N_WAYS=2, `reqs_empty`=1 -> `do_flush`, then 8 `do_ongoing_flush` steps at (0,0),(0,1),(1,0)…(3,1), then `flush_done` for exactly 1 cycle.
- `rsp_valid` pulsed during a walk step at (2,1) -> `do_rsp` that cycle; the next step is (2,1) again and the total step count stays 8.
- `flush_valid` with `reqs_empty`=0 -> no `do_flush` until `reqs_empty` rises. Reset at step 3 -> IDLE, counters 0, no `flush_done`.
